// File: rtl/grf_write_arb.sv
// grf_write_arb
// Two-port write arbiter in front of a single GRF write port. Port 0 is the
// pipeline write-back stage, port 1 is the multi-cycle multiply/divide unit.
// At most one port is granted per cycle. Ties are broken by a round-robin
// pointer that, after each transfer, points at the port that was not granted.
// The granted write is registered onto the GRF write port with 1-cycle latency.
// Writes to $0 are accepted and then dropped: grf_we stays low and grf_wd is 0.
//
// Parameters
//   PRIO_INIT     port holding priority after reset (0 = port 0, 1 = port 1)
// Ports
//   clk, reset               clock, synchronous active-high reset
//   p0_valid/p0_ready        port 0 handshake; p0_pc/p0_addr/p0_data payload
//   p1_valid/p1_ready        port 1 handshake; p1_pc/p1_addr/p1_data payload
//   hold                     freeze: no grants, pointer and counter unchanged
//   grf_we/pc/a3/wd          registered GRF write port
//   conflict_cnt             saturating count of cycles both ports requested
// Optional feature
//   GRF_WRITE_ARB_LOG_EN     when defined, prints "@pc: $addr <= data" once
//                            per transfer edge (simulation logging).
module grf_write_arb #(
  parameter logic PRIO_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_valid,
  output logic        p0_ready,
  input  logic [31:0] p0_pc,
  input  logic [4:0]  p0_addr,
  input  logic [31:0] p0_data,
  input  logic        p1_valid,
  output logic        p1_ready,
  input  logic [31:0] p1_pc,
  input  logic [4:0]  p1_addr,
  input  logic [31:0] p1_data,
  input  logic        hold,
  output logic        grf_we,
  output logic [31:0] grf_pc,
  output logic [4:0]  grf_a3,
  output logic [31:0] grf_wd,
  output logic [15:0] conflict_cnt
);

  logic        rr_ptr_q, rr_ptr_d;
  logic        we_q, we_d;
  logic [31:0] pc_q, pc_d;
  logic [4:0]  a3_q, a3_d;
  logic [31:0] wd_q, wd_d;
  logic [15:0] cnt_q, cnt_d;

  logic        gnt0, gnt1;
  logic        xfer0, xfer1, xfer;
  logic        both_req;
  logic [31:0] sel_pc;
  logic [4:0]  sel_addr;
  logic [31:0] sel_wd;

  // Grant selection: a lone requester wins; on a tie rr_ptr decides.
  always_comb begin
    gnt0 = p0_valid & (~p1_valid | ~rr_ptr_q);
    gnt1 = p1_valid & (~p0_valid |  rr_ptr_q);
  end

  assign p0_ready = p0_valid & ~hold & ~reset & gnt0;
  assign p1_ready = p1_valid & ~hold & ~reset & gnt1;

  assign xfer0    = p0_ready;
  assign xfer1    = p1_ready;
  assign xfer     = xfer0 | xfer1;
  assign both_req = p0_valid & p1_valid & ~hold;

  // Payload mux; $0 data is masked so the GRF never sees a stray value.
  always_comb begin
    sel_pc   = xfer1 ? p1_pc   : p0_pc;
    sel_addr = xfer1 ? p1_addr : p0_addr;
    sel_wd   = (sel_addr == 5'd0) ? 32'd0 : (xfer1 ? p1_data : p0_data);
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    we_d     = 1'b0;
    pc_d     = pc_q;
    a3_d     = a3_q;
    wd_d     = wd_q;
    cnt_d    = cnt_q;
    if (xfer) begin
      // Point at whichever port lost (or did not ask) this time.
      rr_ptr_d = xfer0;
      we_d     = (sel_addr != 5'd0);
      pc_d     = sel_pc;
      a3_d     = sel_addr;
      wd_d     = sel_wd;
    end
    if (both_req && cnt_q != 16'hFFFF)
      cnt_d = cnt_q + 16'd1;
  end

  // Register stage: GRF write port, pointer and conflict counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= PRIO_INIT;
      we_q     <= 1'b0;
      pc_q     <= 32'd0;
      a3_q     <= 5'd0;
      wd_q     <= 32'd0;
      cnt_q    <= 16'd0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      we_q     <= we_d;
      pc_q     <= pc_d;
      a3_q     <= a3_d;
      wd_q     <= wd_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef GRF_WRITE_ARB_LOG_EN
  always_ff @(posedge clk) begin
    if (xfer)
      $display("@%h: $%d <= %h", sel_pc, sel_addr, sel_wd);
  end
`endif

  assign grf_we       = we_q;
  assign grf_pc       = pc_q;
  assign grf_a3       = a3_q;
  assign grf_wd       = wd_q;
  assign conflict_cnt = cnt_q;

endmodule
